logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Shares the two-flop registered logic unit (inputs a/b, outputs y[3:0]: y[0]=a&b, y[1]=a&~b, y[2]=a^b, y[3]=b) between two requesters. Each requester presents an operand pair with a req/ack handshake. The arbiter grants one requester at a time, drives the unit's a/b inputs, and waits for the unit flops to capture and settle. It then registers y[3:0] and returns it with a one-cycle ack. It sits directly in front of the logic unit and owns its input and clear pins.

## Interface
Parameters:
- SETTLE_CYCLES, 1, cycles spent in SETTLE after the unit flops capture; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- req0  in  1  requester 0 request; held high until ack0.
- a0, b0  in  1 each  requester 0 operands.
- req1  in  1  requester 1 request.
- a1, b1  in  1 each  requester 1 operands.
- ack0  out  1  one-cycle pulse: requester 0 result valid on y_out.
- ack1  out  1  one-cycle pulse: requester 1 result valid on y_out.
- y_out  out  4  registered result; holds its value until the next RESP.
- busy  out  1  high in every state except IDLE.
- unit_a, unit_b  out  1 each  registered drive to the unit's a/b flop inputs.
- unit_y  in  4  unit output y[3:0].
- unit_clr  out  1  drives the unit's clr; combinationally equal to clr.
- txn_count  out  8  completed-transaction counter; wraps 255→0.

## Operation
- FSM states: IDLE, LOAD, SETTLE, RESP.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise select a winner per the arbitration policy. Latch the grant index. Register unit_a/unit_b from the winner's a/b. Go to LOAD.
- LOAD: one cycle. Go to SETTLE and load the settle counter with SETTLE_CYCLES-1. The unit flops capture unit_a/unit_b at this exit edge.
- SETTLE:
  - If the counter is nonzero, decrement it and stay.
  - At zero, capture y_out from unit_y, increment txn_count, and go to RESP.
- RESP: one cycle. Assert ack of the granted requester only. Update the last-served pointer. Go to IDLE.
- Arbitration: see Configuration. The winner is sampled only in IDLE; requests arriving mid-transaction wait.
- Dropping req before ack does not abort the transaction; the ack still pulses.
- unit_a/unit_b hold their values from IDLE exit until the next grant.
- Reset values: state=IDLE, ack0=ack1=0, y_out=4'b0000, busy=0, unit_a=unit_b=0, txn_count=0, last-served pointer=1 (so requester 0 wins first).
- clr asserted mid-transaction: everything returns to reset values immediately, no ack is issued, and the unit is cleared via unit_clr.

## Timing
- Edge E0 samples req in IDLE. LOAD occupies the cycle after E0. SETTLE occupies SETTLE_CYCLES cycles. y_out and ack are valid in the cycle after edge E0+1+SETTLE_CYCLES.
- SETTLE_CYCLES=1: ack is high in the 3rd cycle after E0.
- Throughput: one transaction per 3+SETTLE_CYCLES cycles; IDLE always spends at least one cycle between transactions.
- ack0 and ack1 are never high simultaneously; each ack pulse is exactly one cycle.
- busy rises at E0 and falls at the edge leaving RESP.

## Configuration
- RR_ARB_EN defined (round-robin):
  - If both req are high in IDLE, grant the requester that was not last served.
  - A single request is always granted.
- RR_ARB_EN undefined (fixed priority):
  - req0 always wins over req1.
  - The last-served pointer is not implemented; requester 1 may starve.

## Test plan
- Reset, then req0 with a0=1,b0=1 (SETTLE_CYCLES=1) → ack0 pulses 3 cycles after the sampling edge, y_out=4'b1001, txn_count=1.
- req1 with a1=0,b1=1, then a1=1,b1=0, then a1=0,b1=0 → y_out 4'b1100, 4'b0110, 4'b0000 respectively; ack0 never asserts.
- req0 and req1 held high continuously with RR_ARB_EN → acks alternate ack0, ack1, ack0, ack1. Without RR_ARB_EN → only ack0 pulses.
- clr pulsed during SETTLE → no ack issued, y_out=0, txn_count unchanged from reset (0), state IDLE; the next req completes normally.
- 256 back-to-back transactions → txn_count wraps to 0; busy low only in the IDLE cycles between transactions.
- SETTLE_CYCLES=4, req0 with a0=1,b0=0 → ack0 in the 6th cycle after E0, y_out=4'b0110.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of the shared registered logic unit.
// Define RR_ARB_EN for round-robin; default build is fixed priority (req0 wins).
module logic_unit_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req0,
  input  logic       a0,
  input  logic       b0,
  input  logic       req1,
  input  logic       a1,
  input  logic       b1,
  output logic       ack0,
  output logic       ack1,
  output logic [3:0] y_out,
  output logic       busy,
  output logic       unit_a,
  output logic       unit_b,
  input  logic [3:0] unit_y,
  output logic       unit_clr,
  output logic [7:0] txn_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic       grant_q;
  logic       win;
  logic       any_req;
  logic [3:0] cnt_q;

  assign any_req = req0 | req1;

`ifdef RR_ARB_EN
  logic last_q;

  // On contention the requester not served last wins.
  always_comb begin
    win = !req0;
    if (req0 && req1) win = ~last_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      last_q <= 1'b1;
    end else if (state_q == RESP) begin
      last_q <= grant_q;
    end
  end
`else
  always_comb begin
    win = !req0;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = LOAD;
      LOAD:    state_d = SETTLE;
      SETTLE:  if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      unit_a    <= 1'b0;
      unit_b    <= 1'b0;
      cnt_q     <= 4'd0;
      y_out     <= 4'b0000;
      txn_count <= 8'd0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= win;
            unit_a  <= win ? a1 : a0;
            unit_b  <= win ? b1 : b0;
          end
        end
        LOAD: cnt_q <= CNT_INIT;
        SETTLE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            y_out     <= unit_y;
            txn_count <= txn_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ack0     = (state_q == RESP) && !grant_q;
  assign ack1     = (state_q == RESP) && grant_q;
  assign busy     = (state_q != IDLE);
  assign unit_clr = clr;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a behavioural logic unit.
// Second instance runs SETTLE_CYCLES=4.
module tb_logic_unit_arbiter;

  logic       clk;
  logic       clr;
  logic       req0, a0, b0, req1, a1, b1;
  logic       ack0, ack1, busy, unit_a, unit_b, unit_clr;
  logic [3:0] y_out, unit_y;
  logic [7:0] txn_count;

  logic       req0_s, a0_s, b0_s, req1_s, a1_s, b1_s;
  logic       ack0_s, ack1_s, busy_s, unit_a_s, unit_b_s, unit_clr_s;
  logic [3:0] y_out_s, unit_y_s;
  logic [7:0] txn_count_s;

  logic ua_q, ub_q, ua_s_q, ub_s_q;

  int checks;
  int failures;

  logic_unit_arbiter #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .y_out(y_out), .busy(busy),
    .unit_a(unit_a), .unit_b(unit_b), .unit_y(unit_y),
    .unit_clr(unit_clr), .txn_count(txn_count)
  );

  logic_unit_arbiter #(.SETTLE_CYCLES(4)) dut_s4 (
    .clk(clk), .clr(clr),
    .req0(req0_s), .a0(a0_s), .b0(b0_s),
    .req1(req1_s), .a1(a1_s), .b1(b1_s),
    .ack0(ack0_s), .ack1(ack1_s), .y_out(y_out_s), .busy(busy_s),
    .unit_a(unit_a_s), .unit_b(unit_b_s), .unit_y(unit_y_s),
    .unit_clr(unit_clr_s), .txn_count(txn_count_s)
  );

  // Behavioural model of the two-flop logic unit.
  always @(posedge clk or posedge unit_clr) begin
    if (unit_clr) begin
      ua_q <= 1'b0;
      ub_q <= 1'b0;
    end else begin
      ua_q <= unit_a;
      ub_q <= unit_b;
    end
  end

  always @(posedge clk or posedge unit_clr_s) begin
    if (unit_clr_s) begin
      ua_s_q <= 1'b0;
      ub_s_q <= 1'b0;
    end else begin
      ua_s_q <= unit_a_s;
      ub_s_q <= unit_b_s;
    end
  end

  assign unit_y   = {ub_q, ua_q ^ ub_q, ua_q & ~ub_q, ua_q & ub_q};
  assign unit_y_s = {ub_s_q, ua_s_q ^ ub_s_q,
                     ua_s_q & ~ub_s_q, ua_s_q & ub_s_q};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(ack0 | ack1) && cyc < 40);
  endtask

  task automatic txn(input logic sel, input logic a, input logic b,
                     input logic [3:0] ey, input logic [7:0] ecnt);
    int cyc;
    if (sel) begin
      req1 = 1'b1; a1 = a; b1 = b;
    end else begin
      req0 = 1'b1; a0 = a; b0 = b;
    end
    wait_ack(cyc);
    check("latency", cyc, 3);
    check("ack0", ack0, !sel);
    check("ack1", ack1, sel);
    check("y_out", y_out, ey);
    check("txn_count", txn_count, ecnt);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    check("ack_pulse", {ack1, ack0}, 0);
    check("y_hold", y_out, ey);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  initial begin
    int cyc;
    int acks;
    int lows;
    logic exp_sel;
    checks   = 0;
    failures = 0;
    clr  = 1'b1;
    {req0, a0, b0, req1, a1, b1} = '0;
    {req0_s, a0_s, b0_s, req1_s, a1_s, b1_s} = '0;
    tick();
    check("unit_clr_hi", unit_clr, 1);
    clr = 1'b0;
    tick();
    check("rst_unit_clr", unit_clr, 0);
    check("rst_acks", {ack1, ack0}, 0);
    check("rst_y", y_out, 0);
    check("rst_busy", busy, 0);
    check("rst_unit_ab", {unit_a, unit_b}, 0);
    check("rst_cnt", txn_count, 0);

    // clr during SETTLE aborts with no ack
    req0 = 1'b1; a0 = 1'b1; b0 = 1'b1;
    tick();
    check("load_busy", busy, 1);
    check("load_ua", {unit_a, unit_b}, 2'b11);
    tick();
    clr = 1'b1;
    #1;
    check("clr_busy", busy, 0);
    check("clr_unit_clr", unit_clr, 1);
    check("clr_acks", {ack1, ack0}, 0);
    check("clr_ab", {unit_a, unit_b}, 0);
    req0 = 1'b0;
    tick();
    clr = 1'b0;
    tick();
    check("post_clr_acks", {ack1, ack0}, 0);
    check("post_clr_y", y_out, 0);
    check("post_clr_cnt", txn_count, 0);
    check("post_clr_busy", busy, 0);

    txn(1'b0, 1'b1, 1'b1, 4'b1001, 8'd1);
    txn(1'b1, 1'b0, 1'b1, 4'b1100, 8'd2);
    txn(1'b1, 1'b1, 1'b0, 4'b0110, 8'd3);
    txn(1'b1, 1'b0, 1'b0, 4'b0000, 8'd4);

    // both requesters held high
    pulse_clr();
    req0 = 1'b1; a0 = 1'b1; b0 = 1'b1;
    req1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef RR_ARB_EN
      exp_sel = i[0];
`else
      exp_sel = 1'b0;
`endif
      wait_ack(cyc);
      check("both_gap", cyc, (i == 0) ? 3 : 4);
      check("both_acks", {ack1, ack0}, exp_sel ? 2'b10 : 2'b01);
      check("both_y", y_out, exp_sel ? 4'b1100 : 4'b1001);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    // 256 back-to-back transactions
    pulse_clr();
    req0 = 1'b1; a0 = 1'b0; b0 = 1'b1;
    acks = 0;
    lows = 0;
    for (int i = 1; i <= 1024; i++) begin
      tick();
      if (ack1) check("wrap_ack1", ack1, 0);
      if (!busy) begin
        lows++;
        if (i % 4 != 0) check("wrap_busy_phase", i % 4, 0);
      end
      if (ack0) begin
        acks++;
        if (acks == 255) check("cnt_255", txn_count, 255);
      end
    end
    req0 = 1'b0;
    check("wrap_acks", acks, 256);
    check("wrap_lows", lows, 256);
    check("wrap_cnt", txn_count, 0);
    tick();

    // SETTLE_CYCLES=4 instance
    req0_s = 1'b1; a0_s = 1'b1; b0_s = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(ack0_s | ack1_s) && cyc < 40);
    check("s4_latency", cyc, 6);
    check("s4_acks", {ack1_s, ack0_s}, 2'b01);
    check("s4_y", y_out_s, 4'b0110);
    check("s4_cnt", txn_count_s, 1);
    req0_s = 1'b0;
    tick();
    check("s4_idle", busy_s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
